// File: rtl/mult_sequencer_pkg.sv
// Shared types for the multi-cycle MULT/MULTU sequencer.
package mult_sequencer_pkg;

    // state     | meaning
    // S_IDLE    | waiting for start; hi/lo hold the last product
    // S_ABS_A   | replace a negative multiplicand by its magnitude
    // S_ABS_B   | replace a negative multiplier (in lo) by its magnitude
    // S_MUL     | one shift-add iteration per cycle, N cycles
    // S_NEG_LO  | two's-complement negate lo, keep the carry
    // S_NEG_HI  | finish negation of hi using the saved carry
    // S_DONE    | result valid, done pulse
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ABS_A  = 3'd1,
        S_ABS_B  = 3'd2,
        S_MUL    = 3'd3,
        S_NEG_LO = 3'd4,
        S_NEG_HI = 3'd5,
        S_DONE   = 3'd6
    } state_t;

endpackage

// File: rtl/mult_sequencer_adder.sv
// Plain ripple-carry adder shared by the multiply sequencer.
module adder #(
    parameter int n = 33
) (
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    input  logic         cin,
    output logic [n-1:0] sum
);

    // Ripple the carry from bit 0 upward; the final carry-out is discarded.
    always_comb begin
        logic carry;
        carry = cin;
        sum   = '0;
        for (int i = 0; i < n; i++) begin
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
    end

endmodule

// File: rtl/mult_sequencer.sv
// Multi-cycle MULT/MULTU unit: shift-add loop on one shared N+1 bit adder,
// with sign handling done as magnitude conversion before and negation after.
module mult_sequencer
    import mult_sequencer_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         signed_op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] hi,
    output logic [N-1:0] lo
);

    localparam int              CNT_W     = $clog2(N) + 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(N - 1);
    localparam logic [N:0]      ONE       = (N + 1)'(1);

    state_t           state, state_nxt;
    logic [N-1:0]     mcand;
    logic             neg, sign_a, sign_b, signed_q, c;
    logic [CNT_W-1:0] cnt;
    logic [N:0]       add_a, add_b, sum;

    adder #(.n(N + 1)) u_adder (
        .a   (add_a),
        .b   (add_b),
        .cin (1'b0),
        .sum (sum)
    );

    // Steer the shared adder operands according to the current state.
    always_comb begin
        add_a = '0;
        add_b = '0;
        case (state)
            S_ABS_A: begin
                add_a = {1'b0, ~mcand};
                add_b = ONE;
            end
            S_ABS_B, S_NEG_LO: begin
                add_a = {1'b0, ~lo};
                add_b = ONE;
            end
            S_MUL: begin
                add_a = {1'b0, hi};
                add_b = lo[0] ? {1'b0, mcand} : '0;
            end
            S_NEG_HI: begin
                add_a = {1'b0, ~hi};
                add_b = {{N{1'b0}}, c};
            end
            default: ;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state decode and status outputs.
    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = signed_op ? S_ABS_A : S_MUL;
            end
            S_ABS_A:  state_nxt = S_ABS_B;
            S_ABS_B:  state_nxt = S_MUL;
            S_MUL:    if (cnt == LAST_ITER) state_nxt = signed_q ? S_NEG_LO : S_DONE;
            S_NEG_LO: state_nxt = S_NEG_HI;
            S_NEG_HI: state_nxt = S_DONE;
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                busy      = 1'b0;
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath registers: operand capture, sign fix-up and shift-add loop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand    <= '0;
            hi       <= '0;
            lo       <= '0;
            neg      <= 1'b0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            signed_q <= 1'b0;
            c        <= 1'b0;
            cnt      <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    mcand    <= a;
                    lo       <= b;
                    hi       <= '0;
                    neg      <= signed_op & (a[N-1] ^ b[N-1]);
                    sign_a   <= a[N-1];
                    sign_b   <= b[N-1];
                    signed_q <= signed_op;
                    c        <= 1'b0;
                    cnt      <= '0;
                end
                S_ABS_A: if (sign_a) mcand <= sum[N-1:0];
                S_ABS_B: if (sign_b) lo <= sum[N-1:0];
                S_MUL: begin
                    hi  <= sum[N:1];
                    lo  <= {sum[0], lo[N-1:1]};
                    cnt <= cnt + CNT_W'(1);
                end
                S_NEG_LO: if (neg) begin
                    lo <= sum[N-1:0];
                    c  <= sum[N];
                end
                S_NEG_HI: if (neg) hi <= sum[N-1:0];
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_sequencer.sv
// Self-checking bench for mult_sequencer: vector table plus corner sequences,
// results checked through an expected-result queue.
module tb_mult_sequencer;

    localparam int N = 32;

    logic         clk = 1'b0;
    logic         rst, start, signed_op;
    logic [N-1:0] a, b, hi, lo;
    logic         busy, done;

    mult_sequencer #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .signed_op (signed_op),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [63:0] model(input logic s, input logic [N-1:0] x, input logic [N-1:0] y);
        logic [63:0] xe, ye;
        xe = s ? {{N{x[N-1]}}, x} : {{N{1'b0}}, x};
        ye = s ? {{N{y[N-1]}}, y} : {{N{1'b0}}, y};
        return xe * ye;
    endfunction

    typedef struct {
        logic [N-1:0] hi;
        logic [N-1:0] lo;
        int           start_cyc;
        int           lat;
    } exp_t;

    exp_t sb[$];

    typedef struct {
        logic         s;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] eh;
        logic [N-1:0] el;
    } vec_t;

    vec_t vecs[14];

    // Scoreboard side: every done pulse must match the oldest expected result.
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b0 && done === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                check("hi", 64'(hi), 64'(e.hi));
                check("lo", 64'(lo), 64'(e.lo));
                check("latency", 64'(cyc - e.start_cyc), 64'(e.lat));
            end
        end
    end

    task automatic issue(input logic s, input logic [N-1:0] x, input logic [N-1:0] y,
                         input logic [N-1:0] eh, input logic [N-1:0] el);
        exp_t e;
        @(negedge clk);
        start     = 1'b1;
        signed_op = s;
        a         = x;
        b         = y;
        e.hi        = eh;
        e.lo        = el;
        e.start_cyc = cyc;
        e.lat       = s ? N + 5 : N + 1;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
        end
        check({name, "_done_seen"}, 64'(seen), 64'd1);
        #1;
    endtask

    task automatic post_idle(input string name);
        @(negedge clk);
        check({name, "_busy_after"}, 64'(busy), 64'd0);
        check({name, "_done_pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        logic [63:0] p;

        vecs[0] = '{1'b0, 32'd3,         32'd5,         32'h00000000, 32'h0000000F};
        vecs[1] = '{1'b0, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'hFFFFFFFE, 32'h00000001};
        vecs[2] = '{1'b1, 32'hFFFFFFFD,  32'd5,         32'hFFFFFFFF, 32'hFFFFFFF1};
        vecs[3] = '{1'b1, 32'hFFFFFFFF,  32'd0,         32'h00000000, 32'h00000000};
        vecs[4] = '{1'b1, 32'h80000000,  32'h80000000,  32'h40000000, 32'h00000000};
        vecs[5] = '{1'b1, 32'h80000000,  32'd1,         32'hFFFFFFFF, 32'h80000000};
        vecs[6] = '{1'b1, 32'hFFFFFFF9,  32'hFFFFFFFA,  32'h00000000, 32'h0000002A};
        vecs[7] = '{1'b0, 32'h80000000,  32'h80000000,  32'h40000000, 32'h00000000};
        for (int i = 8; i < 14; i++) begin
            vecs[i].s  = 1'(i % 2);
            vecs[i].a  = $urandom;
            vecs[i].b  = $urandom;
            p          = model(vecs[i].s, vecs[i].a, vecs[i].b);
            vecs[i].eh = p[63:32];
            vecs[i].el = p[31:0];
        end

        rst = 1'b1; start = 1'b0; signed_op = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hi",   64'(hi),   64'd0);
        check("rst_lo",   64'(lo),   64'd0);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            issue(vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].eh, vecs[i].el);
            wait_done($sformatf("vec%0d", i));
            post_idle($sformatf("vec%0d", i));
        end

        // Back-to-back: second start in the idle cycle right after DONE.
        issue(1'b0, 32'd1000, 32'd1000, 32'd0, 32'd1000000);
        wait_done("b2b_first");
        issue(1'b1, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA);
        wait_done("b2b_second");
        post_idle("b2b");

        // A second start while busy must be ignored.
        issue(1'b0, 32'd3, 32'd5, 32'd0, 32'd15);
        repeat (3) @(negedge clk);
        check("ign_busy", 64'(busy), 64'd1);
        start = 1'b1; signed_op = 1'b1; a = 32'd9; b = 32'hFFFFFFF7;
        @(negedge clk);
        start = 1'b0;
        wait_done("ignored_start");
        post_idle("ignored_start");
        repeat (N + 8) @(negedge clk);
        check("ign_no_rerun", 64'(busy), 64'd0);

        // Asynchronous reset in the middle of the shift-add loop.
        issue(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_hi",   64'(hi),   64'd0);
        check("midrst_lo",   64'(lo),   64'd0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        issue(1'b0, 32'd7, 32'd6, 32'd0, 32'd42);
        wait_done("after_rst");
        post_idle("after_rst");

        repeat (5) @(negedge clk);
        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
